// File: rtl/dcache_pkg.sv
// Shared dcache definitions: cache op encodings, rewind sequencer states
// and the request record carried on the single dcache request port.
package dcache_pkg;

    // ROB tag width carried in the request record; rewind_ctrl's
    // OOO_TAG_SIZE parameter is expected to match it.
    localparam int ROB_TAG_W = 10;

    typedef enum logic [2:0] {
        NO_OP = 3'd0,
        LD    = 3'd1,
        ST    = 3'd2,
        RD    = 3'd3,
        WR    = 3'd4,
        INV   = 3'd5,
        UPD   = 3'd6,
        WR_LD = 3'd7
    } cache_op_e;

    typedef enum logic [1:0] {
        RW_IDLE   = 2'd0,
        RW_DRAIN  = 2'd1,
        RW_REPLAY = 2'd2,
        RW_DONE   = 2'd3
    } rewind_state_e;

    typedef struct packed {
        logic [31:0]          addr;
        logic [31:0]          data;
        cache_op_e            op;
        logic [1:0]           size;
        logic [ROB_TAG_W-1:0] tag;
    } cache_req_t;

    // Builds a request record from its fields.
    function automatic cache_req_t make_req(
        input logic [31:0]          addr,
        input logic [31:0]          data,
        input cache_op_e            op,
        input logic [1:0]           size,
        input logic [ROB_TAG_W-1:0] tag
    );
        cache_req_t r;
        r.addr = addr;
        r.data = data;
        r.op   = op;
        r.size = size;
        r.tag  = tag;
        return r;
    endfunction

endpackage

// File: rtl/cache_req_reg.sv
// Stall-aware output register for the dcache request port.
// Load captures a new request; while stalled the current request holds;
// once accepted with nothing new to load, valid drops (payload is kept).
// The caller must not assert i_load while a valid request is stalled.
module cache_req_reg
    import dcache_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  cache_req_t i_req,
    input  logic       i_stall,
    output logic       o_valid,
    output cache_req_t o_req
);

    logic       r_valid;
    cache_req_t r_req;

    // Load / hold / clear of the registered request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_req   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_req   <= i_req;
        end else if (!i_stall) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_req   = r_req;

endmodule

// File: rtl/rewind_ctrl.sv
// Rewind sequencer and dcache port arbiter.
// The LSU owns the port in IDLE. A ROB resteer stalls the LSU, waits
// DRAIN_CYCLES for in-flight ops to clear, then replays every flushed
// rewind-buffer entry as a restoring store before handing the port back.
// Optional feature macro: REWIND_CTRL_PERF_EN adds two 16-bit saturating
// counters (perf_rewinds, perf_replays) as output ports.
module rewind_ctrl
    import dcache_pkg::*;
#(
    parameter int OOO_TAG_SIZE = ROB_TAG_W,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rob_resteer,
    input  logic                    rw_valid,
    input  logic                    rw_empty,
    input  logic [31:0]             rw_addr,
    input  logic [31:0]             rw_data,
    input  logic [1:0]              rw_size,
    input  logic [OOO_TAG_SIZE-1:0] rw_tag,
    output logic                    rw_dealloc,
    input  logic                    req_valid,
    input  logic [31:0]             req_addr,
    input  logic [31:0]             req_data,
    input  logic [2:0]              req_op,
    input  logic [1:0]              req_size,
    input  logic [OOO_TAG_SIZE-1:0] req_tag,
    output logic                    req_ready,
    output logic                    cache_valid,
    output logic [31:0]             cache_addr,
    output logic [31:0]             cache_data,
    output logic [2:0]              cache_op,
    output logic [1:0]              cache_size,
    output logic [OOO_TAG_SIZE-1:0] cache_tag,
    input  logic                    cache_stall,
    output logic                    rewind_busy,
    output logic                    rewind_done
`ifdef REWIND_CTRL_PERF_EN
    ,
    output logic [15:0]             perf_rewinds,
    output logic [15:0]             perf_replays
`endif
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    rewind_state_e    r_state;
    rewind_state_e    w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;

    logic       w_pop;
    logic       w_ready;
    logic       w_done;
    logic       w_slot_free;
    logic       w_lsu_load;
    logic       w_load;
    cache_req_t w_lsu_req;
    cache_req_t w_rw_req;
    cache_req_t w_load_req;
    logic       w_out_valid;
    cache_req_t w_out_req;

    // The output slot can take a new request when empty or being accepted.
    assign w_slot_free = !w_out_valid || !cache_stall;

    // State and drain counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RW_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next-state, drain counter and port-ownership decisions.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_pop        = 1'b0;
        w_ready      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            RW_IDLE: begin
                // A resteer refuses the same-cycle LSU request.
                w_ready = !rob_resteer && w_slot_free;
                if (rob_resteer) begin
                    w_next_state = RW_DRAIN;
                    w_next_cnt   = CNT_LOAD;
                end
            end
            RW_DRAIN: begin
                if (rob_resteer) begin
                    w_next_cnt = CNT_LOAD;
                end else if (r_cnt == '0) begin
                    // Wait for any still-stalled issued request to leave.
                    if (!w_out_valid) begin
                        w_next_state = RW_REPLAY;
                    end
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            RW_REPLAY: begin
                // A stalled cache blocks pops even with an empty slot.
                w_pop = rw_valid && !cache_stall;
                if ((rw_empty || !rw_valid) && w_slot_free) begin
                    w_next_state = RW_DONE;
                end
            end
            RW_DONE: begin
                w_done       = 1'b1;
                w_next_state = RW_IDLE;
            end
            default: begin
                w_next_state = RW_IDLE;
            end
        endcase
    end

    assign w_lsu_load = w_ready && req_valid;
    assign w_load     = w_lsu_load || w_pop;
    assign w_lsu_req  = make_req(req_addr, req_data, cache_op_e'(req_op), req_size, req_tag);
    assign w_rw_req   = make_req(rw_addr, rw_data, ST, rw_size, rw_tag);
    assign w_load_req = w_pop ? w_rw_req : w_lsu_req;

    cache_req_reg u_cache_req_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_req   (w_load_req),
        .i_stall (cache_stall),
        .o_valid (w_out_valid),
        .o_req   (w_out_req)
    );

    assign cache_valid = w_out_valid;
    assign cache_addr  = w_out_req.addr;
    assign cache_data  = w_out_req.data;
    assign cache_op    = w_out_req.op;
    assign cache_size  = w_out_req.size;
    assign cache_tag   = w_out_req.tag;

    assign rw_dealloc  = w_pop;
    assign req_ready   = w_ready;
    assign rewind_busy = (r_state != RW_IDLE);
    assign rewind_done = w_done;

`ifdef REWIND_CTRL_PERF_EN
    logic [15:0] r_perf_rewinds;
    logic [15:0] r_perf_replays;

    // Saturating counts of completed passes and replayed entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_rewinds <= '0;
            r_perf_replays <= '0;
        end else begin
            if (w_done && (r_perf_rewinds != 16'hFFFF)) begin
                r_perf_rewinds <= r_perf_rewinds + 16'd1;
            end
            if (w_pop && (r_perf_replays != 16'hFFFF)) begin
                r_perf_replays <= r_perf_replays + 16'd1;
            end
        end
    end

    assign perf_rewinds = r_perf_rewinds;
    assign perf_replays = r_perf_replays;
`endif

endmodule
